// File: rtl/mult_a_stage.sv
// First stage of the pipelined 6x6 signed Baugh-Wooley multiplier: sums partial-product
// rows 0-3 plus 2^6 and registers it with the operands. Define MULT_A_SKID_EN for a two-entry skid buffer.
module mult_a_stage (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] in_a,
  input  logic [5:0] in_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] out_a,
  output logic [5:0] out_b,
  output logic [9:0] out_pin
);

  logic [5:0] pp;
  logic [9:0] pin;
  logic       in_fire;
  logic       out_fire;

  // Rows 0-3 have their sign bit inverted; the 2^6 term is this stage's correction share.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    pp  = '0;
    pin = 10'd64;
    for (int i = 0; i < 4; i++) begin
      pp  = in_b & {6{in_a[i]}};
      pin = pin + (10'({~pp[5], pp[4:0]}) << i);
    end
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

`ifdef MULT_A_SKID_EN
  logic       skid_valid;
  logic [5:0] skid_a;
  logic [5:0] skid_b;
  logic [9:0] skid_pin;

  // Ready comes straight from a flop, so no combinational path from out_ready.
  assign in_ready = !skid_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_a      <= '0;
      out_b      <= '0;
      out_pin    <= '0;
      skid_valid <= 1'b0;
    end else if (out_fire) begin
      if (skid_valid) begin
        out_a      <= skid_a;
        out_b      <= skid_b;
        out_pin    <= skid_pin;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        out_a   <= in_a;
        out_b   <= in_b;
        out_pin <= pin;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_fire) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        out_a     <= in_a;
        out_b     <= in_b;
        out_pin   <= pin;
      end else begin
        skid_valid <= 1'b1;
      end
    end
  end

  // NOTE: skid payload needs no reset; it is only read while skid_valid, which is reset.
  always_ff @(posedge clk) begin
    if (in_fire && out_valid && !out_fire) begin
      skid_a   <= in_a;
      skid_b   <= in_b;
      skid_pin <= pin;
    end
  end
`else
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_pin   <= '0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_a     <= in_a;
      out_b     <= in_b;
      out_pin   <= pin;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_mult_a_stage.sv
// Self-checking bench for mult_a_stage: FIFO scoreboard, Baugh-Wooley second-stage model, random handshakes.
module tb_mult_a_stage;

`ifdef MULT_A_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] in_a = '0;
  logic [5:0] in_b = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [5:0] out_a;
  logic [5:0] out_b;
  logic [9:0] out_pin;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [5:0] a;
    logic [5:0] b;
    logic [9:0] pin;
  } entry_t;

  entry_t q[$];

  mult_a_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_pin(out_pin)
  );

  always #5 clk = ~clk;

  // Row i of the first stage: a_i ? {~b5, b[4:0]} : {1, 00000}, weighted 2^i, plus 64.
  function automatic int ref_pin(logic [5:0] a, logic [5:0] b);
    int s = 64;
    for (int i = 0; i < 4; i++)
      s += (a[i] ? ((b[5] ? 0 : 32) + int'(b[4:0])) : 32) << i;
    return s;
  endfunction

  // Second stage: rows 4 and 5 plus 2^11, modulo 2^12, read as signed.
  function automatic int stage2(logic [5:0] a, logic [5:0] b, logic [9:0] pin);
    int r4, r5, p;
    logic [4:0] nb;
    nb = ~b[4:0];
    r4 = a[4] ? ((b[5] ? 0 : 32) + int'(b[4:0])) : 32;
    r5 = a[5] ? ((b[5] ? 32 : 0) + int'(nb)) : 31;
    p  = (int'(pin) + (r4 << 4) + (r5 << 5) + 2048) % 4096;
    if (p >= 2048) p -= 4096;
    return p;
  endfunction

  function automatic int smul(logic [5:0] a, logic [5:0] b);
    return int'($signed(a)) * int'($signed(b));
  endfunction

  // One clock: inputs already driven; sample mid-cycle, compare against the model, advance.
  task automatic step(output bit accepted);
    bit exp_ready, in_f, out_f;
    entry_t e;
    #1;
    exp_ready = (CAP == 2) ? (q.size() < 2) : (q.size() == 0 || out_ready);
    total++;
    if (in_ready !== exp_ready) begin
      bad++;
      $display("FAIL in_ready: got %b want %b (held=%0d)", in_ready, exp_ready, q.size());
    end
    total++;
    if (out_valid !== (q.size() > 0)) begin
      bad++;
      $display("FAIL out_valid: got %b want %b", out_valid, q.size() > 0);
    end
    if (q.size() > 0) begin
      total++;
      if (out_a !== q[0].a || out_b !== q[0].b || out_pin !== q[0].pin) begin
        bad++;
        $display("FAIL out_data: got a=%0d b=%0d pin=%0d want a=%0d b=%0d pin=%0d",
                 out_a, out_b, out_pin, q[0].a, q[0].b, q[0].pin);
      end
      total++;
      if (stage2(out_a, out_b, out_pin) != smul(q[0].a, q[0].b)) begin
        bad++;
        $display("FAIL product: got %0d want %0d", stage2(out_a, out_b, out_pin),
                 smul(q[0].a, q[0].b));
      end
    end
    in_f  = in_valid && exp_ready;
    out_f = out_ready && (q.size() > 0);
    if (out_f) void'(q.pop_front());
    if (in_f) begin
      e.a = in_a;
      e.b = in_b;
      e.pin = 10'(ref_pin(in_a, in_b));
      q.push_back(e);
    end
    accepted = in_f;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step(acc);
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_a !== 6'd0 || out_b !== 6'd0 || out_pin !== 10'd0) begin
      bad++;
      $display("FAIL reset_state: got v=%b r=%b a=%0d b=%0d pin=%0d want 0 1 0 0 0",
               out_valid, in_ready, out_a, out_b, out_pin);
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_corners();
    logic [5:0] ca[4] = '{6'd1, 6'd0, 6'h3f, 6'h20};
    logic [5:0] cb[4] = '{6'd1, 6'd0, 6'h3f, 6'h20};
    int cpin[4] = '{545, 544, 529, 544};
    int cp[4]   = '{1, 0, 1, 1024};
    bit acc;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_a = ca[k]; in_b = cb[k]; out_ready = 1'b0;
      step(acc);
      in_valid = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b1 || out_pin !== 10'(cpin[k])) begin
        bad++;
        $display("FAIL corner%0d_pin: got v=%b pin=%0d want v=1 pin=%0d", k, out_valid, out_pin, cpin[k]);
      end
      total++;
      if (stage2(out_a, out_b, out_pin) != cp[k]) begin
        bad++;
        $display("FAIL corner%0d_p: got %0d want %0d", k, stage2(out_a, out_b, out_pin), cp[k]);
      end
      @(negedge clk);
      out_ready = 1'b1;
      step(acc);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    bit acc;
    int n = 0;
    out_ready = 1'b1;
    for (int a = 0; a < 64; a++)
      for (int b = 0; b < 64; b++) begin
        in_valid = 1'b1; in_a = 6'(a); in_b = 6'(b);
        step(acc);
        if (acc) n++;
      end
    total++;
    if (n != 4096) begin
      bad++;
      $display("FAIL stream_accepts: got %0d want 4096", n);
    end
    drain();
  endtask

  task automatic test_backpressure();
    bit acc;
    int n = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = 6'($urandom); in_b = 6'($urandom);
      step(acc);
      if (acc) n++;
    end
    total++;
    if (n != CAP) begin
      bad++;
      $display("FAIL backpressure_accepts: got %0d want %0d", n, CAP);
    end
    drain();
  endtask

  task automatic test_random();
    bit acc;
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      in_a = 6'($urandom);
      in_b = 6'($urandom);
      step(acc);
    end
    drain();
  endtask

  task automatic test_async_reset();
    bit acc;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 6'($urandom); in_b = 6'($urandom);
      step(acc);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pin !== 10'd0) begin
      bad++;
      $display("FAIL async_reset: got v=%b r=%b pin=%0d want 0 1 0", out_valid, in_ready, out_pin);
    end
    q.delete();
    #1 rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    step(acc);
    step(acc);
    in_valid = 1'b1; in_a = 6'd37; in_b = 6'd11;
    step(acc);
    in_valid = 1'b1; in_a = 6'd5; in_b = 6'd60;
    step(acc);
    drain();
  endtask

  initial begin
    test_reset();
    test_corners();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_a_stage.md
# mult_a_stage

Registered first stage of the pipelined 6x6 signed Baugh-Wooley multiplier. It accepts operand pairs over a valid/ready handshake and computes the 10-bit intermediate sum of partial-product rows 0–3 plus the 2^6 correction constant. It presents that sum, together with the operands, to the combinational second stage, which adds rows 4–5 and produces the 12-bit product.

## Interface
Parameters: none (operand width fixed at 6, intermediate width fixed at 10).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream operand pair valid
- in_ready  out  1  stage can accept a pair this cycle
- in_a  in  6  multiplier operand a, two's complement
- in_b  in  6  multiplicand operand b, two's complement
- out_valid  out  1  out_a/out_b/out_pin hold a valid result
- out_ready  in  1  downstream accepts the result this cycle
- out_a  out  6  registered copy of a; the second stage uses bits [5:4]
- out_b  out  6  registered copy of b
- out_pin  out  10  intermediate sum, feeds the second stage Pin[9:0]

Reset is asynchronous and active-low; there is one clock.

## Operation
- Partial products, for i = 0..3: pp_i = in_b & {6{in_a[i]}}; row PP_i = {~pp_i[5], pp_i[4:0]}.
- Intermediate sum: pin = PP_0 + (PP_1<<1) + (PP_2<<2) + (PP_3<<3) + 10'd64.
  - The 2^6 constant is this stage's share of the Baugh-Wooley correction; the 2^11 constant belongs to the second stage.
  - Maximum value is 1009, so the sum is exact in 10 bits with no truncation.
- A transfer occurs on a rising edge where valid && ready on the same interface.
- Input transfer: {in_a, in_b, pin} is captured into the result register in the same edge. If the result register is occupied and not draining, the capture goes to the skid entry (see Configuration).
- Output transfer: the register advances to the next entry, or out_valid drops to 0 if none is held.
- Ordering is strictly FIFO. No result is dropped or duplicated.
- The operands are not decoded in any special way. -32 x -32 follows the normal path, giving a final product of +1024.

## Timing
- Reset values (asynchronous on rst_n low):
  - out_valid = 0
  - out_a = 0, out_b = 0, out_pin = 0
  - skid entry empty
  - in_ready = 1
- Latency: one cycle. A pair accepted at edge N is visible on out_* after edge N, with out_valid = 1 in cycle N+1.
- Throughput: one pair per cycle while out_ready = 1.
- Output stability: out_* stay stable while out_valid && !out_ready. They change only after an output transfer or a load into an empty register.
- Simultaneous input and output transfer with one entry held: the new pair replaces the drained one, and out_valid stays 1.
- Reset mid-operation: all held entries are discarded, and no out_valid pulse follows the release of rst_n.
- in_valid is ignored while in_ready = 0. in_a and in_b are sampled only on a transfer edge.

## Configuration
- MULT_A_SKID_EN defined: two-entry buffer (result register plus skid register).
  - in_ready is driven directly from a flop: in_ready = skid entry empty.
  - A pair arriving while the output is stalled goes to the skid entry.
  - On the next output transfer, the skid entry moves to the result register.
- MULT_A_SKID_EN undefined: single entry; in_ready = !out_valid || out_ready (combinational from out_ready).
- Latency and reset values are identical in both builds.

## Test plan
- Reset then single transfer: a=1, b=1 -> out_pin=545 (0x221), out_valid high one cycle after acceptance; the second stage yields P=1.
- Corner operands:
  - a=0, b=0 -> out_pin=544 (0x220)
  - a=-1, b=-1 -> out_pin=529 (0x211), P=1
  - a=-32, b=-32 -> P=1024
- Exhaustive streaming: all 4096 (a,b) pairs back-to-back with out_ready=1 -> sign-extended second-stage P equals a*b for every pair, one result per cycle, order preserved.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1.
  - With MULT_A_SKID_EN, in_ready falls after two accepted pairs.
  - Without it, in_ready falls after one.
  - out_* stay stable while stalled; no loss on release.
- Random valid/ready toggling at 50% each for 10k cycles -> scoreboard matches the input order exactly; in_ready never asserts while the buffer is full.
- Assert rst_n=0 asynchronously between edges while out_valid=1 with a held entry -> out_valid=0 immediately; after release, the first output is the first pair accepted post-reset.
